// File: rtl/apb_slave_bridge.sv
// APB3/APB4 slave front-end: turns APB transfers into a req/ack register-bus access
// with byte enables, address range/alignment checking and a response timeout.
module apb_slave_bridge #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_LO = 32'h0000_0000,
    parameter int unsigned ADDR_HI = 32'h0000_0FFC,
    parameter int unsigned TIMEOUT = 16,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              apb_pclk_i,
    input  logic              apb_presetn_i,
    input  logic [ADDR_W-1:0] apb_paddr_i,
    input  logic              apb_psel_i,
    input  logic              apb_penable_i,
    input  logic              apb_pwrite_i,
    input  logic [DATA_W-1:0] apb_pwdata_i,
    input  logic [STRB_W-1:0] apb_pstrb_i,
    output logic              apb_pready_o,
    output logic [DATA_W-1:0] apb_prdata_o,
    output logic              apb_pslverr_o,
    output logic              reg_req_o,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [DATA_W-1:0] reg_wdata_o,
    output logic [STRB_W-1:0] reg_be_o,
    input  logic [DATA_W-1:0] reg_rdata_i,
    input  logic              reg_ack_i,
    input  logic              reg_err_i,
    output logic              reg_rd_done_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LO_C       = ADDR_W'(ADDR_LO);
    localparam logic [ADDR_W-1:0] HI_C       = ADDR_W'(ADDR_HI);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               pready_r;
    logic               pslverr_r;
    logic [DATA_W-1:0]  prdata_r;
    logic               req_r;
    logic               we_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  wdata_r;
    logic [STRB_W-1:0]  be_r;
    logic               rd_done_r;
    logic               timeout_hit_s;

    // Range checks use an extended subtraction so a zero lower bound does not fold to a constant compare.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] lo_diff;
        logic [ADDR_W:0] hi_diff;
        lo_diff = {1'b0, addr} - {1'b0, LO_C};
        hi_diff = {1'b0, HI_C} - {1'b0, addr};
        addr_ok = !lo_diff[ADDR_W] && !hi_diff[ADDR_W] &&
                  ((addr & ALIGN_MASK) == {ADDR_W{1'b0}});
    endfunction

    // Counter holds the number of REQ cycles already elapsed, so the last allowed cycle is TIMEOUT-1.
    assign timeout_hit_s = (TIMEOUT != 32'd0) && (cnt_r == CNT_W'(TIMEOUT - 32'd1));

    // Transfer FSM with all outputs registered.
    always_ff @(posedge apb_pclk_i or negedge apb_presetn_i) begin
        if (!apb_presetn_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= {DATA_W{1'b0}};
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            be_r      <= {STRB_W{1'b0}};
            rd_done_r <= 1'b0;
        end else begin
            rd_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    if (apb_psel_i && !apb_penable_i) begin
                        addr_r  <= apb_paddr_i;
                        wdata_r <= apb_pwdata_i;
                        we_r    <= apb_pwrite_i;
                        be_r    <= apb_pwrite_i ? apb_pstrb_i : {STRB_W{1'b1}};
                        cnt_r   <= {CNT_W{1'b0}};
                        if (addr_ok(apb_paddr_i)) begin
                            state_r <= ST_REQ;
                            req_r   <= 1'b1;
                        end else begin
                            state_r   <= ST_RESP;
                            pready_r  <= 1'b1;
                            pslverr_r <= 1'b1;
                            prdata_r  <= {DATA_W{1'b0}};
                        end
                    end
                end
                ST_REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (reg_ack_i) begin
                        state_r   <= ST_RESP;
                        req_r     <= 1'b0;
                        pready_r  <= 1'b1;
                        pslverr_r <= reg_err_i;
                        prdata_r  <= (!we_r && !reg_err_i) ? reg_rdata_i : {DATA_W{1'b0}};
                    end else if (timeout_hit_s) begin
                        state_r   <= ST_RESP;
                        req_r     <= 1'b0;
                        pready_r  <= 1'b1;
                        pslverr_r <= 1'b1;
                        prdata_r  <= {DATA_W{1'b0}};
                    end
                end
                ST_RESP: begin
                    if (apb_penable_i || !apb_psel_i) begin
                        state_r   <= ST_IDLE;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                        rd_done_r <= !we_r && !pslverr_r;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_r     <= 1'b0;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    assign apb_pready_o  = pready_r;
    assign apb_pslverr_o = pslverr_r;
    assign apb_prdata_o  = prdata_r;
    assign reg_req_o     = req_r;
    assign reg_we_o      = we_r;
    assign reg_addr_o    = addr_r;
    assign reg_wdata_o   = wdata_r;
    assign reg_be_o      = be_r;
    assign reg_rd_done_o = rd_done_r;

endmodule
